// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures the period and high time of a slow square wave that is
//   asynchronous to the 100 MHz system clock. Both are reported as clock-cycle
//   counts through a valid/ready output register.
//
// Ports
//   i_clk_100MHz  system clock; all logic runs on its rising edge
//   i_rst         synchronous, active-high reset
//   i_sig         signal under measurement (asynchronous)
//   o_period      cycles between two successive rising edges of i_sig
//   o_high_time   cycles from rising to falling edge within that period
//   o_valid       o_period / o_high_time hold an unconsumed result
//   i_ready       consumer accepts the result when o_valid & i_ready
//   o_timeout     level; no rising edge seen within TIMEOUT_CYCLES
//   o_overrun     sticky; a completed result was dropped (output still full)
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic             i_clk_100MHz,
  input  logic             i_rst,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_timeout,
  output logic             o_overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sig_p0;
  logic             r_sig_p1;
  logic             r_sig_p2;
  logic             w_rise;
  logic             w_fall;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_tmp;

  logic             w_arm;
  logic             w_cpl;
  logic             w_fall_cap;
  logic             w_tmo;
  logic             w_load;
  logic             w_drop;
  logic             w_accept;

  // Stage p0/p1: two-flop synchronizer; p2 is the edge-detect history.
  // All three reset to 0, so a signal already high at reset release yields
  // one rise, which only arms the measurement.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) begin
      r_sig_p0 <= 1'b0;
      r_sig_p1 <= 1'b0;
      r_sig_p2 <= 1'b0;
    end else begin
      r_sig_p0 <= i_sig;
      r_sig_p1 <= r_sig_p0;
      r_sig_p2 <= r_sig_p1;
    end
  end

  assign w_rise = r_sig_p1 & ~r_sig_p2;
  assign w_fall = ~r_sig_p1 & r_sig_p2;

  // State register
  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. A rise in MEASURE ends one period and starts the next,
  // so the FSM stays put; only a timeout falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_rise) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (!w_rise && (r_cnt == TIMEOUT_VAL)) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Action decode. A rise that completes a period takes priority over the
  // timeout, which is why w_tmo excludes w_rise.
  always_comb begin
    w_arm      = (r_state == ST_IDLE) && w_rise;
    w_cpl      = (r_state == ST_MEASURE) && w_rise;
    w_fall_cap = (r_state == ST_MEASURE) && w_fall;
    w_tmo      = (r_state == ST_MEASURE) && !w_rise && (r_cnt == TIMEOUT_VAL);
    w_load     = w_cpl && (!o_valid || i_ready);
    w_drop     = w_cpl && o_valid && !i_ready;
    w_accept   = o_valid && i_ready;
  end

  // Counter: restarts at 1 on every rise so that the pre-update value seen on
  // the next rise (or fall) is the exact cycle count since this rise.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if ((r_state == ST_MEASURE) && !w_tmo) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) begin
      r_high_tmp <= '0;
    end else if (w_arm) begin
      r_high_tmp <= '0;
    end else if (w_fall_cap) begin
      r_high_tmp <= r_cnt;
    end
  end

  // Result register: loads only when empty or being drained this same cycle;
  // otherwise the held result wins and the overrun flag records the loss.
  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) begin
      o_period    <= '0;
      o_high_time <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      if (w_load) begin
        o_period    <= r_cnt;
        o_high_time <= r_high_tmp;
        o_valid     <= 1'b1;
      end else if (w_accept) begin
        o_valid     <= 1'b0;
      end

      if (w_drop) o_overrun <= 1'b1;

      if (w_arm)      o_timeout <= 1'b0;
      else if (w_tmo) o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_sig;
  logic             i_ready;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high_time;
  logic             o_valid;
  logic             o_timeout;
  logic             o_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .i_clk_100MHz (clk),
    .i_rst        (i_rst),
    .i_sig        (i_sig),
    .o_period     (o_period),
    .o_high_time  (o_high_time),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input period: high for hi cycles then low for per-hi cycles.
  // The rise of this call completes the previous period; its result lands on
  // the third edge after i_sig goes high.
  //   mode 0: no checks
  //   mode 1: streaming (i_ready=1): valid low before, one-cycle pulse at result
  //   mode 2: held (i_ready=0): new values visible at result edge
  //   mode 3: i_ready pulsed exactly on the completion cycle while valid=1
  task automatic sq(input int per, input int hi, input int mode,
                    input logic [31:0] ep, input logic [31:0] eh);
    i_sig = 1'b1;
    tick();
    tick();
    if (mode == 1) check("lat_pre_valid", o_valid, 0);
    if (mode == 3) i_ready = 1'b1;
    tick();
    if (mode == 3) i_ready = 1'b0;
    if (mode != 0) begin
      check("res_valid", o_valid, 1);
      check("res_period", o_period, ep);
      check("res_high", o_high_time, eh);
    end
    if (mode == 3) check("acc_cpl_overrun", o_overrun, 0);
    tick();
    if (mode == 1) check("pulse_valid_drop", o_valid, 0);
    repeat (hi - 4) tick();
    i_sig = 1'b0;
    repeat (per - hi) tick();
  endtask

  initial begin
    i_rst   = 1'b1;
    i_sig   = 1'b0;
    i_ready = 1'b1;

    // Reset with the input toggling
    for (int i = 0; i < 5; i++) begin
      i_sig = i[0];
      tick();
    end
    check("rst_valid", o_valid, 0);
    check("rst_period", o_period, 0);
    check("rst_high", o_high_time, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_overrun", o_overrun, 0);
    i_sig = 1'b0;
    i_rst = 1'b0;
    repeat (4) tick();

    // Steady 100/30 wave, i_ready=1; first rise arms only
    sq(100, 30, 0, 0, 0);
    check("arm_no_valid", o_valid, 0);
    sq(100, 30, 1, 100, 30);
    sq(100, 30, 1, 100, 30);
    sq(100, 30, 1, 100, 30);

    // Simultaneous accept and complete
    i_ready = 1'b0;
    sq(110, 40, 2, 100, 30);
    sq(100, 30, 3, 110, 40);

    // Backpressure: held result survives two more completions
    sq(120, 40, 0, 0, 0);
    check("bp_hold_valid", o_valid, 1);
    check("bp_hold_period", o_period, 110);
    check("bp_hold_high", o_high_time, 40);
    check("bp_overrun", o_overrun, 1);
    sq(99, 30, 0, 0, 0);
    check("bp_hold2_period", o_period, 110);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("bp_drain_valid", o_valid, 0);
    check("bp_overrun_sticky", o_overrun, 1);
    sq(100, 50, 2, 100, 30);

    // Timeout: the rise above is the last one; rise acted on at P3,
    // sq returns after P100, timeout registers at P1003.
    i_ready = 1'b1;
    tick();
    check("to_drain_valid", o_valid, 0);
    repeat (901) tick();
    check("to_not_yet", o_timeout, 0);
    tick();
    check("to_set", o_timeout, 1);
    repeat (20) tick();
    check("to_level", o_timeout, 1);
    check("to_no_valid", o_valid, 0);
    check("to_period_kept", o_period, 100);

    // Resume 100/50 wave: first rise clears timeout and arms
    sq(100, 50, 0, 0, 0);
    check("resume_timeout_clr", o_timeout, 0);
    check("resume_no_valid", o_valid, 0);
    sq(100, 50, 1, 100, 50);

    // Reset 60 cycles into a period
    i_sig = 1'b1;
    repeat (30) tick();
    i_sig = 1'b0;
    repeat (30) tick();
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_period", o_period, 0);
    check("mid_rst_high", o_high_time, 0);
    check("mid_rst_overrun", o_overrun, 0);
    repeat (10) tick();
    check("mid_rst_no_result", o_valid, 0);
    sq(100, 30, 0, 0, 0);
    check("mid_rst_arm_only", o_valid, 0);
    sq(100, 30, 1, 100, 30);
    check("final_overrun", o_overrun, 0);
    check("final_timeout", o_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
